// File: rtl/dsc_op_sequencer.sv
// Operation sequencer for one deterministic stochastic-computing core.
// The optional performance counters are enabled by defining DSC_SEQ_PERF_EN.
module dsc_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned CNT_WIDTH  = 17
) (
    input  logic                             gclk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [CNT_WIDTH-1:0]             in_budget,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
    input  logic                             core_op_finished,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]             out_cycles,
    output logic                             out_truncated,
`ifdef DSC_SEQ_PERF_EN
    input  logic                             perf_clr,
    output logic [31:0]                      perf_ops,
    output logic [47:0]                      perf_cycles,
    output logic [31:0]                      perf_trunc,
`endif
    output logic                             busy
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StSettle, StDone} state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cyc_q;
    logic [CNT_WIDTH-1:0] budget_q;
    logic [CNT_WIDTH-1:0] cyc_inc;
    logic                 trunc_q;
    logic                 budget_hit;
    logic                 cyc_sat;

    assign cyc_inc    = cyc_q + CNT_WIDTH'(1);
    assign budget_hit = (budget_q != '0) && (cyc_inc == budget_q);
    assign cyc_sat    = (cyc_inc == '1);

    // Gated by rst so nothing is offered while the sequencer is being reset.
    assign in_ready = (state_q == StIdle) && !rst;

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q       <= StIdle;
            core_rst      <= 1'b1;
            core_en       <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            out_data      <= '0;
            out_cycles    <= '0;
            out_truncated <= 1'b0;
            core_data_in  <= '0;
            cyc_q         <= '0;
            budget_q      <= '0;
            trunc_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        core_data_in <= in_data;
                        budget_q     <= in_budget;
                        cyc_q        <= '0;
                        trunc_q      <= 1'b0;
                        busy         <= 1'b1;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    core_rst <= 1'b0;
                    core_en  <= 1'b1;
                    state_q  <= StRun;
                end
                StRun: begin
                    cyc_q <= cyc_inc;
                    // Completion takes priority, so a tie with the budget is not truncation.
                    if (core_op_finished) begin
                        trunc_q <= 1'b0;
                        core_en <= 1'b0;
                        state_q <= StSettle;
                    end else if (budget_hit || cyc_sat) begin
                        trunc_q <= 1'b1;
                        core_en <= 1'b0;
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    out_data      <= core_data_out;
                    out_cycles    <= cyc_q;
                    out_truncated <= trunc_q;
                    out_valid     <= 1'b1;
                    core_rst      <= 1'b1;
                    state_q       <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef DSC_SEQ_PERF_EN
    logic [32:0] ops_sum;
    logic [48:0] cycles_sum;
    logic [32:0] trunc_sum;

    assign ops_sum    = {1'b0, perf_ops} + 33'd1;
    assign cycles_sum = {1'b0, perf_cycles} + 49'(cyc_q);
    assign trunc_sum  = {1'b0, perf_trunc} + 33'(trunc_q);

    // Carry-out of each sum selects saturation at all-ones.
    always_ff @(posedge gclk) begin
        if (rst || perf_clr) begin
            perf_ops    <= '0;
            perf_cycles <= '0;
            perf_trunc  <= '0;
        end else if (state_q == StSettle) begin
            perf_ops    <= ops_sum[32] ? '1 : ops_sum[31:0];
            perf_cycles <= cycles_sum[48] ? '1 : cycles_sum[47:0];
            perf_trunc  <= trunc_sum[32] ? '1 : trunc_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Scoreboard bench for dsc_op_sequencer with a behavioural DSC core model.
// Also exercises the performance counters when DSC_SEQ_PERF_EN is defined.
module tb_dsc_op_sequencer;

    logic        gclk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [16:0] in_budget;
    logic        core_rst;
    logic        core_en;
    logic [15:0] core_data_in;
    logic [15:0] core_data_out;
    logic        core_op_finished;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [16:0] out_cycles;
    logic        out_truncated;
    logic        busy;
`ifdef DSC_SEQ_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_ops;
    logic [47:0] perf_cycles;
    logic [31:0] perf_trunc;
`endif

    dsc_op_sequencer #(
        .DATA_WIDTH(8),
        .NUM_INPUTS(2),
        .CNT_WIDTH (17)
    ) dut (
        .gclk            (gclk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_budget       (in_budget),
        .core_rst        (core_rst),
        .core_en         (core_en),
        .core_data_in    (core_data_in),
        .core_data_out   (core_data_out),
        .core_op_finished(core_op_finished),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_cycles      (out_cycles),
        .out_truncated   (out_truncated),
`ifdef DSC_SEQ_PERF_EN
        .perf_clr        (perf_clr),
        .perf_ops        (perf_ops),
        .perf_cycles     (perf_cycles),
        .perf_trunc      (perf_trunc),
`endif
        .busy            (busy)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    int cyc_cnt = 0;
    always @(posedge gclk) cyc_cnt <= cyc_cnt + 1;

    // Core model: finishes on its fin_n-th enabled cycle; result ramps to a*b.
    int core_cnt;
    int fin_n;
    always @(posedge gclk) begin
        if (core_rst) core_cnt <= 0;
        else if (core_en) core_cnt <= core_cnt + 1;
    end
    assign core_op_finished = core_en && (core_cnt == fin_n - 1);
    assign core_data_out = 16'((int'(core_data_in[7:0]) * int'(core_data_in[15:8]) * core_cnt)
                               / fin_n);

    typedef struct {
        logic [15:0] data;
        logic [16:0] cycles;
        logic        trunc;
        int          latency;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accept_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    initial begin
        int   en_seen;
        logic prev_valid;
        exp_t e;
        en_seen    = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge gclk);
            if (rst) begin
                en_seen    = 0;
                prev_valid = 1'b0;
            end else begin
                if (core_en) en_seen++;
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got out_valid=1, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_cycles", out_cycles, e.cycles);
                        chk("out_truncated", out_truncated, e.trunc);
                        chk("latency", cyc_cnt - accept_cyc, e.latency);
                        chk("core_en_cycles", en_seen, e.cycles);
                    end
                    en_seen = 0;
                end
                prev_valid = out_valid;
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [16:0] budget,
                          input int fin, input bit expect_res, input logic [15:0] edata,
                          input logic [16:0] ecyc, input logic etrunc);
        int   w;
        exp_t e;
        @(negedge gclk);
        fin_n     = fin;
        in_data   = {b, a};
        in_budget = budget;
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge gclk);
            w++;
        end
        chk("accept_timeout", in_ready, 1'b1);
        accept_cyc = cyc_cnt;
        if (expect_res) begin
            e.data    = edata;
            e.cycles  = ecyc;
            e.trunc   = etrunc;
            e.latency = int'(ecyc) + 3;
            exp_q.push_back(e);
        end
        @(negedge gclk);
        in_valid  = 1'b0;
        in_data   = 16'hA5A5;
        in_budget = 17'd1;
        chk("in_ready_busy", in_ready, 1'b0);
        @(negedge gclk);
        chk("core_data_in_held", core_data_in, {b, a});
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (!out_valid && w < 300) begin
            @(negedge gclk);
            w++;
        end
        chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic finish_op();
        wait_valid();
        @(negedge gclk);
        chk("out_valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] snap_data;
        logic [16:0] snap_cyc;
        logic        snap_trunc;
        bit          saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_budget = '0;
        out_ready = 1'b1;
        fin_n     = 37;
`ifdef DSC_SEQ_PERF_EN
        perf_clr  = 1'b0;
`endif
        repeat (3) begin
            @(negedge gclk);
            chk("in_ready_in_reset", in_ready, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_out_cycles", out_cycles, 17'd0);
        chk("rst_core_data_in", core_data_in, 16'd0);
`ifdef DSC_SEQ_PERF_EN
        chk("rst_perf_ops", perf_ops, 32'd0);
`endif

        // Natural completion, held in DONE by backpressure.
        out_ready = 1'b0;
        run_op(8'd13, 8'd200, 17'd0, 37, 1'b1, 16'd2600, 17'd37, 1'b0);
        wait_valid();
        snap_data  = 16'd2600;
        snap_cyc   = 17'd37;
        snap_trunc = 1'b0;
        repeat (10) begin
            @(negedge gclk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, snap_data);
            chk("bp_out_cycles", out_cycles, snap_cyc);
            chk("bp_out_truncated", out_truncated, snap_trunc);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge gclk);
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_release_busy", busy, 1'b0);

        // Budget truncation: 2600*16/37 = 1124.
        run_op(8'd13, 8'd200, 17'd16, 37, 1'b1, 16'd1124, 17'd16, 1'b1);
        finish_op();
        // Short natural op, 3*7 = 21.
        run_op(8'd3, 8'd7, 17'd0, 5, 1'b1, 16'd21, 17'd5, 1'b0);
        finish_op();
`ifdef DSC_SEQ_PERF_EN
        chk("perf_ops", perf_ops, 32'd3);
        chk("perf_cycles", perf_cycles, 48'd58);
        chk("perf_trunc", perf_trunc, 32'd1);
        perf_clr = 1'b1;
        @(negedge gclk);
        perf_clr = 1'b0;
        chk("perf_ops_clr", perf_ops, 32'd0);
        chk("perf_cycles_clr", perf_cycles, 48'd0);
        chk("perf_trunc_clr", perf_trunc, 32'd0);
`endif

        // Finish and budget coincide: completion wins.
        run_op(8'd13, 8'd200, 17'd16, 16, 1'b1, 16'd2600, 17'd16, 1'b0);
        finish_op();

        // Abort mid-RUN.
        run_op(8'd13, 8'd200, 17'd0, 37, 1'b0, 16'd0, 17'd0, 1'b0);
        repeat (10) @(negedge gclk);
        chk("abort_running", core_en, 1'b1);
        rst = 1'b1;
        @(negedge gclk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_core_en", core_en, 1'b0);
        chk("abort_core_rst", core_rst, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_data", out_data, 16'd0);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (60) begin
            @(negedge gclk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_result", saw_valid, 1'b0);

        // Recovery after abort.
        run_op(8'd3, 8'd7, 17'd0, 5, 1'b1, 16'd21, 17'd5, 1'b0);
        finish_op();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
